// File: rtl/dand_mem_pkg.sv
// Shared types and helpers for the dcache memory responder.
package dand_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } mem_state_e;

    localparam logic [63:0] DefaultBaseAddr = 64'h8000_0000;

    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                      input int unsigned depth);
        return (addr >= base) && ((addr - base) < (64'(depth) << 3));
    endfunction

endpackage

// File: rtl/dand_mem_array.sv
// DEPTH x 64-bit word store: byte-masked write port and a registered read port
// loaded only when a read is accepted.
module dand_mem_array
    import dand_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic          rhit,
    input  logic [AW-1:0] idx,
    input  logic [63:0]   wdata,
    input  logic [7:0]    wstrb,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;
    logic [63:0] wmask;

    assign wmask = strb_to_mask(wstrb);

    // Store contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= rhit ? mem[idx] : 64'h0;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache cmd/rsp port with programmable read latency.
// Define DCACHE_RSP_ERR_EN to add rsp_payload_error and err_sticky outputs.
module dcache_mem_responder
    import dand_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 1,
    parameter logic [63:0] BASE_ADDR = DefaultBaseAddr
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_payload_addr,
    input  logic        cmd_payload_wen,
    input  logic [63:0] cmd_payload_wdata,
    input  logic [7:0]  cmd_payload_wstrb,
    input  logic [2:0]  cmd_payload_size,
    output logic        rsp_valid,
    output logic [63:0] rsp_payload_data
`ifdef DCACHE_RSP_ERR_EN
    ,
    output logic        rsp_payload_error,
    output logic        err_sticky
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e    state_q;
    logic [CntW-1:0] cnt_q;
    logic          pend_rd_q;
    logic          rsp_valid_q;
    logic [63:0]   data_q;
    logic [63:0]   rd_data;
    logic [63:0]   off;
    logic          hit;
    logic          accept;
    logic          unused_bits;

    assign off       = cmd_payload_addr - BASE_ADDR;
    assign hit       = in_range(cmd_payload_addr, BASE_ADDR, DEPTH);
    assign cmd_ready = (state_q == StIdle) || (state_q == StResp);
    assign accept    = cmd_valid && cmd_ready;
    assign unused_bits = ^{off[63:AW+3], off[2:0], cmd_payload_size};

`ifdef DCACHE_RSP_ERR_EN
    logic misalign;
    logic req_err;
    logic pend_err_q;
    logic rsp_err_q;
    logic sticky_q;

    assign misalign = (cmd_payload_addr & ((64'd1 << cmd_payload_size) - 64'd1)) != 64'd0;
    assign req_err  = !hit || misalign;
    assign rsp_payload_error = rsp_err_q;
    assign err_sticky        = sticky_q;
`endif

    dand_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (accept && cmd_payload_wen && hit),
        .re    (accept && !cmd_payload_wen),
        .rhit  (hit),
        .idx   (off[3 +: AW]),
        .wdata (cmd_payload_wdata),
        .wstrb (cmd_payload_wstrb),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pend_rd_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            data_q      <= '0;
`ifdef DCACHE_RSP_ERR_EN
            pend_err_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            sticky_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            // Latch the word just presented so the output holds it between pulses.
            if (rsp_valid_q) begin
                data_q <= rd_data;
            end
`ifdef DCACHE_RSP_ERR_EN
            rsp_err_q <= 1'b0;
            if (accept && cmd_payload_wen && req_err) begin
                sticky_q <= 1'b1;
            end
`endif
            unique case (state_q)
                StIdle, StResp: begin
                    if (accept) begin
                        pend_rd_q <= !cmd_payload_wen;
`ifdef DCACHE_RSP_ERR_EN
                        pend_err_q <= req_err;
`endif
                        if (LATENCY == 1) begin
                            state_q     <= StResp;
                            rsp_valid_q <= !cmd_payload_wen;
`ifdef DCACHE_RSP_ERR_EN
                            rsp_err_q   <= !cmd_payload_wen && req_err;
`endif
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntW'(LATENCY - 1);
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q     <= StResp;
                        rsp_valid_q <= pend_rd_q;
`ifdef DCACHE_RSP_ERR_EN
                        rsp_err_q   <= pend_rd_q && pend_err_q;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_payload_data = rsp_valid_q ? rd_data : data_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Three responders (LATENCY 1, 3, 4) driven from per-instance command queues and
// compared every cycle against a transaction-level model of the store and timing.
module tb_dcache_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          NDUT  = 3;
    localparam int          GUARD = 20000;

    typedef struct packed {
        logic        idle;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [2:0]  size;
    } cmd_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        c_valid [NDUT];
    logic        c_ready [NDUT];
    logic [63:0] c_addr  [NDUT];
    logic        c_wen   [NDUT];
    logic [63:0] c_wdata [NDUT];
    logic [7:0]  c_wstrb [NDUT];
    logic [2:0]  c_size  [NDUT];
    logic        r_valid [NDUT];
    logic [63:0] r_data  [NDUT];
`ifdef DCACHE_RSP_ERR_EN
    logic        r_err    [NDUT];
    logic        e_sticky [NDUT];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dcache_mem_responder #(
            .DEPTH     (DEPTH),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .BASE_ADDR (BASE)
        ) u_dut (
            .clk               (clk),
            .reset             (reset),
            .cmd_valid         (c_valid[g]),
            .cmd_ready         (c_ready[g]),
            .cmd_payload_addr  (c_addr[g]),
            .cmd_payload_wen   (c_wen[g]),
            .cmd_payload_wdata (c_wdata[g]),
            .cmd_payload_wstrb (c_wstrb[g]),
            .cmd_payload_size  (c_size[g]),
            .rsp_valid         (r_valid[g]),
            .rsp_payload_data  (r_data[g])
`ifdef DCACHE_RSP_ERR_EN
            ,
            .rsp_payload_error (r_err[g]),
            .err_sticky        (e_sticky[g])
`endif
        );
    end

    // Reference model: word store, next cycle the port is free, scheduled response.
    int          lat [NDUT] = '{1, 3, 4};
    logic [63:0] mdl [NDUT][DEPTH];
    int          ready_from [NDUT];
    int          rsp_cyc [NDUT];
    logic [63:0] rsp_val [NDUT];
    logic [63:0] last_data [NDUT];
    logic        rsp_err [NDUT];
    logic        sticky [NDUT];
    cmd_t        cq [NDUT][$];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int d, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d got=%h exp=%h", tag, d, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            ready_from[d] = 0;
            rsp_cyc[d]    = -1;
            rsp_val[d]    = '0;
            last_data[d]  = '0;
            rsp_err[d]    = 1'b0;
            sticky[d]     = 1'b0;
            cq[d].delete();
        end
    endtask

    task automatic model_accept(input int d, input cmd_t c);
        logic hit;
        logic bad;
        int   idx;
        hit = (c.addr >= BASE) && (c.addr < BASE + 64'(DEPTH) * 8);
        idx = hit ? int'((c.addr - BASE) / 8) : 0;
        bad = !hit || ((c.addr % (64'd1 << c.size)) != 64'd0);
        ready_from[d] = cyc + lat[d];
        if (c.wen) begin
            if (hit) begin
                for (int b = 0; b < 8; b++) begin
                    if (c.wstrb[b]) mdl[d][idx][8*b +: 8] = c.wdata[8*b +: 8];
                end
            end
            if (bad) sticky[d] = 1'b1;
        end else begin
            rsp_cyc[d] = cyc + lat[d];
            rsp_val[d] = hit ? mdl[d][idx] : 64'h0;
            rsp_err[d] = bad;
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < NDUT; d++) begin
            logic pulse;
            pulse = (cyc == rsp_cyc[d]);
            check("cmd_ready", d, 64'(c_ready[d]), 64'(cyc >= ready_from[d]));
            check("rsp_valid", d, 64'(r_valid[d]), 64'(pulse));
            check("rsp_data", d, r_data[d], pulse ? rsp_val[d] : last_data[d]);
`ifdef DCACHE_RSP_ERR_EN
            if (pulse) check("rsp_error", d, 64'(r_err[d]), 64'(rsp_err[d]));
            check("err_sticky", d, 64'(e_sticky[d]), 64'(sticky[d]));
`endif
            if (pulse) last_data[d] = rsp_val[d];
        end
    endtask

    task automatic drive(input int d);
        cmd_t c;
        c_valid[d] = 1'b0;
        if (cq[d].size() == 0) return;
        c = cq[d][0];
        if (c.idle) begin
            void'(cq[d].pop_front());
            return;
        end
        c_valid[d] = 1'b1;
        c_addr[d]  = c.addr;
        c_wen[d]   = c.wen;
        c_wdata[d] = c.wdata;
        c_wstrb[d] = c.wstrb;
        c_size[d]  = c.size;
        // Held unchanged until the model says the port is free at the coming edge.
        if (cyc >= ready_from[d]) begin
            void'(cq[d].pop_front());
            model_accept(d, c);
        end
    endtask

    task automatic step(input logic rst);
        @(negedge clk);
        check_outputs();
        if (rst) begin
            reset = 1'b1;
            model_reset();
            for (int d = 0; d < NDUT; d++) c_valid[d] = 1'b0;
        end else begin
            reset = 1'b0;
            for (int d = 0; d < NDUT; d++) drive(d);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((cq[0].size() + cq[1].size() + cq[2].size()) != 0 && guard < GUARD) begin
            step(1'b0);
            guard++;
        end
        checks++;
        assert (guard < GUARD) else begin
            errors++;
            $error("FAIL drain_timeout got=%0d limit=%0d", guard, GUARD);
        end
        run(6);
    endtask

    task automatic push(input int d, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wstrb,
                        input logic [2:0] size);
        cmd_t c;
        c.idle  = 1'b0;
        c.addr  = addr;
        c.wen   = wen;
        c.wdata = wdata;
        c.wstrb = wstrb;
        c.size  = size;
        cq[d].push_back(c);
    endtask

    function automatic logic [63:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        int   sel;
        int   s;
        c.idle = ($urandom_range(0, 3) == 0);
        sel    = $urandom_range(0, 9);
        case (sel)
            7:       c.addr = BASE - 64'd8;
            8:       c.addr = BASE + 64'(DEPTH) * 8;
            9:       c.addr = BASE + 64'(DEPTH) * 8 - 64'd8;
            default: c.addr = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
        endcase
        c.wen   = $urandom_range(0, 1) == 1;
        c.wdata = rand_word();
        s       = $urandom_range(0, 7);
        c.wstrb = (s == 0) ? 8'h00 : ((s < 3) ? 8'hFF : 8'($urandom));
        c.size  = 3'($urandom_range(0, 3));
        return c;
    endfunction

    initial begin
        logic [63:0] a;
        for (int d = 0; d < NDUT; d++) begin
            c_valid[d] = 1'b0;
            c_addr[d]  = '0;
            c_wen[d]   = 1'b0;
            c_wdata[d] = '0;
            c_wstrb[d] = '0;
            c_size[d]  = '0;
        end
        model_reset();
        #1 reset = 1'b1;
        step(1'b1);
        step(1'b1);

        // Fill every store so later reads have defined contents.
        for (int i = 0; i < DEPTH; i++) begin
            for (int d = 0; d < NDUT; d++) begin
                push(d, 1'b1, BASE + 64'(i) * 8, rand_word(), 8'hFF, 3'd3);
            end
        end
        drain();

        // Full write, read back, partial write, read back on LATENCY=1.
        push(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 3'd3);
        push(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 3'd3);
        push(0, 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 3'd3);
        push(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 3'd3);
        drain();

        // Back-to-back reads held valid on LATENCY=3.
        for (int i = 0; i < 4; i++) push(1, 1'b0, BASE + 64'($urandom_range(0, 31)) * 8, 0, 0, 3'd3);
        drain();

        // Range boundaries and dropped out-of-range writes on all instances.
        for (int d = 0; d < NDUT; d++) begin
            push(d, 1'b0, 64'h7FFF_FFF8, 0, 0, 3'd3);
            push(d, 1'b0, BASE + 64'(DEPTH) * 8, 0, 0, 3'd3);
            push(d, 1'b1, BASE + 64'(DEPTH) * 8, rand_word(), 8'hFF, 3'd3);
            push(d, 1'b1, BASE - 64'd8, rand_word(), 8'hFF, 3'd3);
            push(d, 1'b0, BASE, 0, 0, 3'd3);
            push(d, 1'b0, BASE + 64'(DEPTH) * 8 - 64'd8, 0, 0, 3'd3);
            push(d, 1'b1, 64'h8000_0001, rand_word(), 8'h06, 3'd1);
            push(d, 1'b0, 64'h8000_0000, 0, 0, 3'd3);
        end
        drain();

        // Reset while a LATENCY=4 read is in WAIT; the prior write must survive.
        a = BASE + 64'h40;
        push(2, 1'b1, a, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 3'd3);
        drain();
        push(2, 1'b0, a, 0, 0, 3'd3);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        run(8);
        push(2, 1'b0, a, 0, 0, 3'd3);
        drain();

        // Continuous LATENCY=1 reads: a new accept in every response cycle.
        for (int i = 0; i < 8; i++) push(0, 1'b0, BASE + 64'(i) * 8, 0, 0, 3'd3);
        drain();

        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (cq[d].size() == 0) cq[d].push_back(rand_cmd());
            end
            step(1'b0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
